// File: rtl/merge_pkg.sv
// Shared definitions for the merge-sort lower layer: FSM state encoding,
// default geometry and the counter-width helper.
package merge_pkg;

    typedef enum logic [1:0] {
        FILL,
        SORT,
        SERVE
    } state_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_L_SIZE = 4;
    localparam int DEFAULT_R_SIZE = 4;

    // Counters must be able to hold the value SIZE itself, not just SIZE-1.
    function automatic int cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/merge_run_buf.sv
// One sorted run: indexed fill, odd-even transposition pass, head-first pop
// with zero fill at the top, and a remaining-element count.
module merge_run_buf
    import merge_pkg::*;
#(
    parameter int SIZE   = DEFAULT_L_SIZE,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CW     = cnt_w(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [CW-1:0]     wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              sort_en_i,
    input  logic              sort_odd_i,
    input  logic              shift_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     rem_o
);

    logic [DATA_W-1:0] data_q [SIZE];
    logic [DATA_W-1:0] data_d [SIZE];
    logic [CW-1:0]     rem_q;
    logic [CW-1:0]     rem_d;

    // Next-state: the operations are exclusive because each belongs to one FSM state.
    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        if (clear_i) begin
            rem_d = '0;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (wr_idx_i == CW'(i)) begin
                    data_d[i] = wr_data_i;
                end
            end
            rem_d = rem_q + CW'(1);
        end else if (sort_en_i) begin
            // Pairs in one pass are disjoint, so every swap reads the registered values.
            for (int unsigned i = 0; i + 1 < SIZE; i++) begin
                if ((((i % 2) != 0) == sort_odd_i) && (data_q[i+1] < data_q[i])) begin
                    data_d[i]   = data_q[i+1];
                    data_d[i+1] = data_q[i];
                end
            end
        end else if (shift_i && (rem_q != '0)) begin
            for (int unsigned i = 0; i + 1 < SIZE; i++) begin
                data_d[i] = data_q[i+1];
            end
            data_d[SIZE-1] = '0;
            rem_d          = rem_q - CW'(1);
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '{default: '0};
            rem_q  <= '0;
        end else begin
            data_q <= data_d;
            rem_q  <= rem_d;
        end
    end

    assign head_o = data_q[0];
    assign rem_o  = rem_q;

endmodule

// File: rtl/merge_lower_layer.sv
// Producer side of the merge-sort layer: fills one L+R chunk, sorts both runs
// ascending in place, then serves them head-first to the upper merge layer.
// Optional macro MERGE_LOWER_ERR_EN adds a sticky protocol-error output err.
module merge_lower_layer
    import merge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int L_SIZE = DEFAULT_L_SIZE,
    parameter int R_SIZE = DEFAULT_R_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              shift_en_L,
    input  logic              shift_en_R,
    input  logic              update,
    input  logic              done_upper,
    output logic              done_lower,
    output logic              load_L,
    output logic              load_R,
    output logic              cmp,
    output logic [DATA_W-1:0] head_L,
    output logic [DATA_W-1:0] head_R
`ifdef MERGE_LOWER_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int TOTAL = L_SIZE + R_SIZE;
    localparam int NPASS = (L_SIZE > R_SIZE) ? L_SIZE : R_SIZE;
    localparam int FW    = cnt_w(TOTAL);
    localparam int SW    = cnt_w(NPASS);
    localparam int LW    = cnt_w(L_SIZE);
    localparam int RW    = cnt_w(R_SIZE);

    localparam logic [FW-1:0] FILL_LAST = FW'(TOTAL - 1);
    localparam logic [FW-1:0] L_LIM     = FW'(L_SIZE);
    localparam logic [SW-1:0] SORT_LAST = SW'(NPASS - 1);

    state_e        state_q;
    logic [FW-1:0] fill_cnt_q;
    logic [SW-1:0] sort_cnt_q;
    logic          done_lower_q;

    logic          accept;
    logic          wr_l;
    logic          wr_r;
    logic [LW-1:0] idx_l;
    logic [RW-1:0] idx_r;
    logic          sort_en;
    logic          serve;
    logic          rel_serve;
    logic          pop_l;
    logic          pop_r;
    logic [LW-1:0] rem_l;
    logic [RW-1:0] rem_r;

    // The upper layer's busy flag carries no meaning for this block.
    logic unused_update;
    assign unused_update = update;

    assign serve     = (state_q == SERVE);
    assign accept    = (state_q == FILL) && in_valid;
    assign wr_l      = accept && (fill_cnt_q < L_LIM);
    assign wr_r      = accept && !(fill_cnt_q < L_LIM);
    assign idx_l     = LW'(fill_cnt_q);
    assign idx_r     = RW'(fill_cnt_q - L_LIM);
    assign sort_en   = (state_q == SORT);
    assign rel_serve = serve && done_upper;
    // A release wins over a shift issued in the same cycle.
    assign pop_l     = serve && !done_upper && shift_en_L;
    assign pop_r     = serve && !done_upper && shift_en_R;

    merge_run_buf #(
        .SIZE   (L_SIZE),
        .DATA_W (DATA_W)
    ) u_run_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_l),
        .wr_idx_i   (idx_l),
        .wr_data_i  (in_data),
        .sort_en_i  (sort_en),
        .sort_odd_i (sort_cnt_q[0]),
        .shift_i    (pop_l),
        .clear_i    (rel_serve),
        .head_o     (head_L),
        .rem_o      (rem_l)
    );

    merge_run_buf #(
        .SIZE   (R_SIZE),
        .DATA_W (DATA_W)
    ) u_run_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_r),
        .wr_idx_i   (idx_r),
        .wr_data_i  (in_data),
        .sort_en_i  (sort_en),
        .sort_odd_i (sort_cnt_q[0]),
        .shift_i    (pop_r),
        .clear_i    (rel_serve),
        .head_o     (head_R),
        .rem_o      (rem_r)
    );

    // FSM with fill/pass counters and the registered done_lower pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            fill_cnt_q   <= '0;
            sort_cnt_q   <= '0;
            done_lower_q <= 1'b0;
        end else begin
            done_lower_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (fill_cnt_q == FILL_LAST) begin
                            fill_cnt_q <= '0;
                            sort_cnt_q <= '0;
                            state_q    <= SORT;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + FW'(1);
                        end
                    end
                end
                SORT: begin
                    if (sort_cnt_q == SORT_LAST) begin
                        sort_cnt_q   <= '0;
                        done_lower_q <= 1'b1;
                        state_q      <= SERVE;
                    end else begin
                        sort_cnt_q <= sort_cnt_q + SW'(1);
                    end
                end
                SERVE: begin
                    if (done_upper) begin
                        fill_cnt_q <= '0;
                        sort_cnt_q <= '0;
                        state_q    <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Head comparator: ties favour L to keep the merge stable.
    always_comb begin
        cmp = 1'b0;
        if ((rem_l != '0) && (rem_r != '0)) begin
            cmp = (head_L <= head_R);
        end else if (rem_l != '0) begin
            cmp = 1'b1;
        end
    end

    assign in_ready   = (state_q == FILL);
    assign done_lower = done_lower_q;
    assign load_L     = serve && (rem_l != '0);
    assign load_R     = serve && (rem_r != '0);

`ifdef MERGE_LOWER_ERR_EN
    logic err_q;
    logic err_evt;

    assign err_evt = ((shift_en_L || shift_en_R) && !serve)
                   || (serve && shift_en_L && (rem_l == '0))
                   || (serve && shift_en_R && (rem_r == '0))
                   || (rel_serve && ((rem_l != '0) || (rem_r != '0)));

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_merge_lower_layer.sv
// Self-checking bench for merge_lower_layer: a 4+4 instance and a 2+5 instance
// share one stimulus bus selected by sel.
module tb_merge_lower_layer;

    typedef logic [7:0] batch_t [8];

    typedef struct {
        logic       shl;
        logic       shr;
        logic       cmp;
        logic [7:0] hl;
        logic [7:0] hr;
        logic       ldl;
        logic       ldr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic       drv_shl;
    logic       drv_shr;
    logic       drv_upd;
    logic       drv_done_up;

    always #5 clk = ~clk;

    logic       in_valid1, shl1, shr1, done_up1;
    logic       in_valid2, shl2, shr2, done_up2;
    logic       in_ready1, done_lower1, load_L1, load_R1, cmp1;
    logic       in_ready2, done_lower2, load_L2, load_R2, cmp2;
    logic [7:0] head_L1, head_R1, head_L2, head_R2;

    assign in_valid1 = drv_valid & ~sel;
    assign shl1      = drv_shl & ~sel;
    assign shr1      = drv_shr & ~sel;
    assign done_up1  = drv_done_up & ~sel;
    assign in_valid2 = drv_valid & sel;
    assign shl2      = drv_shl & sel;
    assign shr2      = drv_shr & sel;
    assign done_up2  = drv_done_up & sel;

`ifdef MERGE_LOWER_ERR_EN
    logic err1, err2, o_err;
    assign o_err = sel ? err2 : err1;
`endif

    merge_lower_layer #(
        .DATA_W (8),
        .L_SIZE (4),
        .R_SIZE (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_data    (drv_data),
        .in_ready   (in_ready1),
        .shift_en_L (shl1),
        .shift_en_R (shr1),
        .update     (drv_upd),
        .done_upper (done_up1),
        .done_lower (done_lower1),
        .load_L     (load_L1),
        .load_R     (load_R1),
        .cmp        (cmp1),
        .head_L     (head_L1),
        .head_R     (head_R1)
`ifdef MERGE_LOWER_ERR_EN
        ,
        .err        (err1)
`endif
    );

    merge_lower_layer #(
        .DATA_W (8),
        .L_SIZE (2),
        .R_SIZE (5)
    ) dut_25 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid2),
        .in_data    (drv_data),
        .in_ready   (in_ready2),
        .shift_en_L (shl2),
        .shift_en_R (shr2),
        .update     (drv_upd),
        .done_upper (done_up2),
        .done_lower (done_lower2),
        .load_L     (load_L2),
        .load_R     (load_R2),
        .cmp        (cmp2),
        .head_L     (head_L2),
        .head_R     (head_R2)
`ifdef MERGE_LOWER_ERR_EN
        ,
        .err        (err2)
`endif
    );

    logic       o_in_ready, o_done_lower, o_load_L, o_load_R, o_cmp;
    logic [7:0] o_head_L, o_head_R;

    assign o_in_ready   = sel ? in_ready2   : in_ready1;
    assign o_done_lower = sel ? done_lower2 : done_lower1;
    assign o_load_L     = sel ? load_L2     : load_L1;
    assign o_load_R     = sel ? load_R2     : load_R1;
    assign o_cmp        = sel ? cmp2        : cmp1;
    assign o_head_L     = sel ? head_L2     : head_L1;
    assign o_head_R     = sel ? head_R2     : head_R1;

    int         errors = 0;
    int         checks = 0;
    int         lsz = 4;
    logic [7:0] expL [$];
    logic [7:0] expR [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input bit shl, input bit shr, input bit c,
                                 input int hl, input int hr, input bit ll, input bit lr);
        vec_t v;
        v.shl = shl;
        v.shr = shr;
        v.cmp = c;
        v.hl  = 8'(hl);
        v.hr  = 8'(hr);
        v.ldl = ll;
        v.ldr = lr;
        return v;
    endfunction

    // Drive n words; the model's sorted runs are queued as the words are sent.
    task automatic fill_words(input batch_t w, input int n, input bit gaps, input bit hold);
        logic [7:0] tl [$];
        logic [7:0] tr [$];
        int         p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("in_ready_fill", o_in_ready, 1);
            drv_valid = 1'b1;
            drv_data  = w[i];
            p = 0;
            if (i < lsz) begin
                while (p < tl.size() && tl[p] <= w[i]) p++;
                tl.insert(p, w[i]);
            end else begin
                while (p < tr.size() && tr[p] <= w[i]) p++;
                tr.insert(p, w[i]);
            end
            if (gaps && (i != n - 1)) begin
                @(negedge clk);
                drv_valid = 1'b0;
                drv_data  = 8'hEE;
            end
        end
        foreach (tl[i]) expL.push_back(tl[i]);
        foreach (tr[i]) expR.push_back(tr[i]);
        @(negedge clk);
        drv_valid = hold;
        drv_data  = 8'hFF;
    endtask

    task automatic wait_sorted(input int n);
        int cnt;
        cnt = 0;
        chk("in_ready_sort", o_in_ready, 0);
        chk("done_early", o_done_lower, 0);
        while (o_done_lower !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("sort_latency", cnt, n);
        @(negedge clk);
        chk("done_pulse_width", o_done_lower, 0);
        drv_valid = 1'b0;
    endtask

    // Pops whichever run the model says to take, checking every head on the way.
    task automatic drain_sb();
        int guard;
        guard = 0;
        while ((expL.size() + expR.size()) != 0 && guard < 40) begin
            logic       mc;
            logic [7:0] el;
            logic [7:0] er;
            @(negedge clk);
            guard++;
            el = (expL.size() != 0) ? expL[0] : 8'd0;
            er = (expR.size() != 0) ? expR[0] : 8'd0;
            mc = (expL.size() != 0 && expR.size() != 0) ? (el <= er) : (expL.size() != 0);
            chk("sb_cmp", o_cmp, mc);
            chk("sb_head_L", o_head_L, el);
            chk("sb_head_R", o_head_R, er);
            chk("sb_load_L", o_load_L, expL.size() != 0);
            chk("sb_load_R", o_load_R, expR.size() != 0);
            drv_shl = mc;
            drv_shr = !mc;
            if (mc) void'(expL.pop_front());
            else    void'(expR.pop_front());
        end
        @(negedge clk);
        drv_shl = 1'b0;
        drv_shr = 1'b0;
        chk("empty_cmp", o_cmp, 0);
        chk("empty_heads", {o_head_L, o_head_R}, 0);
        chk("empty_loads", {o_load_L, o_load_R}, 0);
    endtask

    task automatic release_bufs();
        @(negedge clk);
        drv_done_up = 1'b1;
        @(negedge clk);
        drv_done_up = 1'b0;
        chk("in_ready_after_release", o_in_ready, 1);
        chk("done_after_release", o_done_lower, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        batch_t b;
        vec_t   tbl [9];

        tbl[0] = mkv(1, 0, 1, 1, 2, 1, 1);
        tbl[1] = mkv(0, 1, 0, 3, 2, 1, 1);
        tbl[2] = mkv(1, 0, 1, 3, 4, 1, 1);
        tbl[3] = mkv(0, 1, 0, 7, 4, 1, 1);
        tbl[4] = mkv(0, 1, 0, 7, 6, 1, 1);
        tbl[5] = mkv(1, 0, 1, 7, 8, 1, 1);
        tbl[6] = mkv(0, 1, 0, 9, 8, 1, 1);
        tbl[7] = mkv(1, 0, 1, 9, 0, 1, 0);
        tbl[8] = mkv(0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        sel = 1'b0;
        drv_valid = 1'b0;
        drv_data = 8'h00;
        drv_shl = 1'b0;
        drv_shr = 1'b0;
        drv_upd = 1'b0;
        drv_done_up = 1'b0;

        #12;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_done", o_done_lower, 0);
        chk("rst_cmp", o_cmp, 0);
        chk("rst_heads", {o_head_L, o_head_R}, 0);
        chk("rst_loads", {o_load_L, o_load_R}, 0);
`ifdef MERGE_LOWER_ERR_EN
        chk("rst_err", o_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fill, then the scripted merge sequence.
        b = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd4, 8'd8, 8'd2, 8'd6};
        fill_words(b, 8, 1'b0, 1'b0);
        wait_sorted(4);
        drv_upd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_cmp", i), o_cmp, tbl[i].cmp);
            chk($sformatf("tbl%0d_head_L", i), o_head_L, tbl[i].hl);
            chk($sformatf("tbl%0d_head_R", i), o_head_R, tbl[i].hr);
            chk($sformatf("tbl%0d_load_L", i), o_load_L, tbl[i].ldl);
            chk($sformatf("tbl%0d_load_R", i), o_load_R, tbl[i].ldr);
            drv_shl = tbl[i].shl;
            drv_shr = tbl[i].shr;
            if (tbl[i].shl) void'(expL.pop_front());
            if (tbl[i].shr) void'(expR.pop_front());
        end
        drv_upd = 1'b0;
`ifdef MERGE_LOWER_ERR_EN
        chk("err_clean_merge", o_err, 0);
`endif
        release_bufs();

        // Equal heads: ties go to L, then popping an empty L changes nothing.
        b = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        fill_words(b, 8, 1'b0, 1'b0);
        wait_sorted(4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("eq_cmp", o_cmp, 1);
            chk("eq_head_L", o_head_L, 5);
            chk("eq_head_R", o_head_R, 5);
            drv_shl = 1'b1;
            void'(expL.pop_front());
        end
        @(negedge clk);
        chk("eq_cmp_L_empty", o_cmp, 0);
        chk("eq_load_L_empty", o_load_L, 0);
        chk("eq_head_L_empty", o_head_L, 0);
        chk("eq_head_R_kept", o_head_R, 5);
        @(negedge clk);
        drv_shl = 1'b0;
        chk("pop_empty_head_L", o_head_L, 0);
        chk("pop_empty_head_R", o_head_R, 5);
        chk("pop_empty_load_R", o_load_R, 1);
`ifdef MERGE_LOWER_ERR_EN
        chk("pop_empty_err", o_err, 1);
`endif
        drain_sb();
        release_bufs();

        // Gapped fill with in_valid held high through SORT.
        b = '{8'd20, 8'd10, 8'd30, 8'd40, 8'd15, 8'd5, 8'd25, 8'd35};
        fill_words(b, 8, 1'b1, 1'b1);
        wait_sorted(4);
        drain_sb();
        release_bufs();

        // Reset during SORT discards the partial batch.
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd8, 8'd7, 8'd6};
        fill_words(b, 8, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", o_in_ready, 1);
        chk("midrst_done", o_done_lower, 0);
        chk("midrst_cmp", o_cmp, 0);
        chk("midrst_heads", {o_head_L, o_head_R}, 0);
        chk("midrst_loads", {o_load_L, o_load_R}, 0);
`ifdef MERGE_LOWER_ERR_EN
        chk("midrst_err", o_err, 0);
`endif
        expL.delete();
        expR.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        fill_words(b, 8, 1'b0, 1'b0);
        wait_sorted(4);
        drain_sb();
        release_bufs();

        // Unequal runs: L_SIZE=2, R_SIZE=5.
        sel = 1'b1;
        lsz = 2;
        b = '{8'd9, 8'd3, 8'd50, 8'd40, 8'd10, 8'd30, 8'd20, 8'd0};
        fill_words(b, 7, 1'b0, 1'b0);
        wait_sorted(5);
        drain_sb();
        release_bufs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
